stream_mux_rr: RTL
==================

Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit stream multiplexer with per-channel valid/ready handshake and one registered output stage.
- Two modes: fixed select, where a sel input picks the channel, and round-robin arbitration across all valid channels.
- Next generation of the team's 4:1 16-bit combinational mux. Sits between datapath producers and a single shared consumer.

Parameters:
- WIDTH, 16, data bits per channel.
- NUM_CH, 4, number of input channels (2..16).
- SEL_W, $clog2(NUM_CH), localparam derived from NUM_CH; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_data  in  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NUM_CH  per-channel valid.
- in_ready  out  NUM_CH  per-channel ready; combinational.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SEL_W  channel index used in fixed mode.
- out_data  out  WIDTH  registered data.
- out_valid  out  1  registered valid.
- out_ch  out  SEL_W  index of the source channel for out_data.
- out_ready  in  1  consumer ready.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0.
  - in_ready is 0 for all channels while rst=1.
- load_en = !out_valid || out_ready. Full throughput: one beat per cycle when out_ready is held at 1.
- Grant (combinational, at most one channel):
  - mode=0: grant sel when in_valid[sel]=1. No grant if in_valid[sel]=0 or sel >= NUM_CH.
  - mode=1: grant the first i with in_valid[i]=1, searching ptr, ptr+1, ... and wrapping modulo NUM_CH.
- in_ready[g] = load_en && grant_valid && (g == granted channel). All other in_ready bits are 0.
- Transfer at a clk edge when in_valid[g] && in_ready[g]:
  - out_data <= in_data[g]; out_ch <= g; out_valid <= 1.
  - In mode=1, ptr <= (g+1) mod NUM_CH.
- If load_en=1 and there is no grant, out_valid <= 0 at the edge.
- If out_valid=1 and out_ready=0, out_data and out_ch hold stable and all in_ready are 0 (back-pressure).
- Latency is 1 cycle from input transfer to out_valid.
- ptr updates only on mode=1 transfers. It is retained across mode changes and across mode=0 operation.
- sel and mode are sampled every cycle. A change affects only the next grant and never a beat already registered.
- Reset mid-stream: the registered beat is dropped. No input is accepted in the reset cycle.
- Producers must hold in_data stable while in_valid=1 and in_ready=0.

Optional Feature:
- Macro: STREAM_MUX_GRANT_CNT_EN.
- Defined:
  - Adds output grant_cnt, NUM_CH*16 bits: one 16-bit counter per channel.
  - A counter increments on each transfer from its channel and saturates at 16'hFFFF.
  - Counters clear on rst.
  - Adds input cnt_clr (1 bit), a synchronous clear of all counters. cnt_clr takes priority over an increment in the same cycle.
- Undefined: the port and the counters are absent; behaviour is otherwise identical.

Decomposition:
- Package stream_mux_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - Default WIDTH and NUM_CH constants.
  - Counter width constant GRANT_CNT_W=16.
- Sub-module rr_arbiter (NUM_CH):
  - Inputs: req vector, ptr.
  - Outputs: grant_valid, grant_idx.
  - Purely combinational; the ptr register stays in the top module.

Test Plan:
- Reset, then mode=0, sel=2, in_valid=4'b0100, in_data ch2=16'hBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=16'hBEEF, out_ch=2.
- mode=1, all four channels valid continuously, data = channel index, out_ready=1 -> out_ch sequence 0,1,2,3,0,1; one beat per cycle.
- mode=1, in_valid=4'b1001 with ptr=1 -> channel 3 granted first, then ptr=0 and channel 0 granted, then channel 3 again (wrap-around).
- Beat held with out_ready=0 for 3 cycles while ch1 valid -> out_data/out_ch stable; in_ready=0 throughout; ch1 accepted in the cycle out_ready returns to 1.
- mode=0, sel=1, in_valid=4'b0001 -> no grant, out_valid=0. Switching to mode=1 grants ch0 next cycle.
- With STREAM_MUX_GRANT_CNT_EN: 5 transfers from ch2 -> grant_cnt[2]=5. cnt_clr asserted together with a transfer -> counter reads 0. Assert rst during a held beat -> out_valid=0 next cycle.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants for the round-robin stream multiplexer.
// No logic, no latency.
// No flow control.
package stream_mux_pkg;

    localparam logic MODE_FIXED  = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    localparam int   DEF_WIDTH   = 16;
    localparam int   DEF_NUM_CH  = 4;

    localparam int   GRANT_CNT_W = 16;

endpackage

// File: rtl/stream_mux_rr_if.sv
// Stream bus between N producers, the multiplexer and the shared consumer.
// No latency; a plain signal bundle.
// Carries per-channel valid/ready and the single output valid/ready pair.
interface stream_mux_rr_if
    import stream_mux_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_CH = DEF_NUM_CH
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_ready;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin request picker: first requester at or after i_ptr, wrapping.
// Purely combinational, zero latency.
// No flow control; the caller qualifies the grant with its own load enable.
module rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         i_req,
    input  logic [$clog2(NUM_CH)-1:0] i_ptr,
    output logic                      o_grant_valid,
    output logic [$clog2(NUM_CH)-1:0] o_grant_idx
);
    localparam int SEL_W = $clog2(NUM_CH);

    // Walk from the farthest offset back to i_ptr so the nearest requester wins.
    always_comb begin
        int w_c;
        w_c           = 0;
        o_grant_valid = 1'b0;
        o_grant_idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_c = int'(i_ptr) + k;
            if (w_c >= NUM_CH) begin
                w_c = w_c - NUM_CH;
            end
            if (i_req[SEL_W'(w_c)]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = SEL_W'(w_c);
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 stream mux, fixed-select or round-robin; optional per-channel grant counters (STREAM_MUX_GRANT_CNT_EN).
// One registered output stage: 1 cycle from input transfer to out_valid, full throughput.
// Output stall holds the registered beat and drops every in_ready; nothing accepted in reset.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic                          clk,
    input  logic                          rst,
    stream_mux_rr_if.slave                bus
`ifdef STREAM_MUX_GRANT_CNT_EN
    ,
    input  logic                          cnt_clr,
    output logic [NUM_CH*GRANT_CNT_W-1:0] grant_cnt
`endif
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_valid;
    logic [SEL_W-1:0]  r_out_ch;
    logic [SEL_W-1:0]  r_ptr;

    logic [WIDTH-1:0]  w_ch_data [NUM_CH];
    logic              w_load_en;
    logic              w_sel_in_range;
    logic              w_fixed_vld;
    logic              w_arb_valid;
    logic [SEL_W-1:0]  w_arb_idx;
    logic              w_grant_valid;
    logic [SEL_W-1:0]  w_grant_idx;
    logic [SEL_W-1:0]  w_ptr_nxt;
    logic              w_xfer;
    logic [NUM_CH-1:0] w_in_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign w_ch_data[i] = bus.in_data[i*WIDTH +: WIDTH];
    end

    // A select index past the last channel only exists when NUM_CH is not a power of two.
    if ((1 << SEL_W) == NUM_CH) begin : g_sel_pow2
        assign w_sel_in_range = 1'b1;
    end else begin : g_sel_npow2
        assign w_sel_in_range = (32'(bus.sel) < NUM_CH);
    end

    rr_arbiter #(
        .NUM_CH        (NUM_CH)
    ) u_arb (
        .i_req         (bus.in_valid),
        .i_ptr         (r_ptr),
        .o_grant_valid (w_arb_valid),
        .o_grant_idx   (w_arb_idx)
    );

    assign w_load_en     = !r_out_valid || bus.out_ready;
    assign w_fixed_vld   = w_sel_in_range && bus.in_valid[bus.sel];
    assign w_grant_valid = (bus.mode == MODE_RR) ? w_arb_valid : w_fixed_vld;
    assign w_grant_idx   = (bus.mode == MODE_RR) ? w_arb_idx   : bus.sel;
    assign w_ptr_nxt     = (w_grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : w_grant_idx + 1'b1;
    assign w_xfer        = !rst && w_load_en && w_grant_valid;

    always_comb begin
        w_in_ready = '0;
        if (w_xfer) begin
            w_in_ready[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= '0;
        end else if (w_load_en) begin
            if (w_grant_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_ch_data[w_grant_idx];
                r_out_ch    <= w_grant_idx;
                if (bus.mode == MODE_RR) begin
                    r_ptr <= w_ptr_nxt;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_ch    = r_out_ch;

`ifdef STREAM_MUX_GRANT_CNT_EN
    logic [GRANT_CNT_W-1:0] r_cnt [NUM_CH];

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_xfer && (r_cnt[w_grant_idx] != '1)) begin
            r_cnt[w_grant_idx] <= r_cnt[w_grant_idx] + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt_out
        assign grant_cnt[i*GRANT_CNT_W +: GRANT_CNT_W] = r_cnt[i];
    end
`endif

endmodule
